// File: rtl/quadra_pipe_pkg.sv
// Shared widths, types and helpers for the pipelined piecewise-quadratic evaluator.
package quadra_pkg;
    localparam int X_W      = 24;
    localparam int SEG_W    = 7;
    localparam int A_W      = 30;
    localparam int B_W      = 22;
    localparam int C_W      = 14;
    localparam int X2_SHIFT = 6;
    localparam int T1_SH    = 0;
    localparam int T2_SH    = 0;
    localparam int R_F      = 6;
    localparam int Y_W      = 20;

    localparam int DEPTH = 2**SEG_W;
    localparam int X2_W  = X_W - SEG_W;
    localparam int XS_W  = X2_W - X2_SHIFT;
    localparam int SQ_W  = 2*X2_W - 2*X2_SHIFT;
    // Product widths include one extra bit for the zero-extended unsigned operand.
    localparam int T1_W  = B_W + XS_W + 1;
    localparam int T2_W  = C_W + SQ_W + 1;

    function automatic int maxOf3(input int p, input int q, input int r);
        int m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    localparam int SUM_W = maxOf3(A_W, T1_W, T2_W) + 2;

    typedef logic        [X_W-1:0]   x_t;
    typedef logic        [SEG_W-1:0] x1_t;
    typedef logic        [X2_W-1:0]  x2_t;
    typedef logic        [XS_W-1:0]  xs_t;
    typedef logic        [SQ_W-1:0]  sq_t;
    typedef logic signed [A_W-1:0]   a_t;
    typedef logic signed [B_W-1:0]   b_t;
    typedef logic signed [C_W-1:0]   c_t;
    typedef logic signed [T1_W-1:0]  t1_t;
    typedef logic signed [T2_W-1:0]  t2_t;
    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic signed [Y_W-1:0]   y_t;

    typedef struct packed {
        a_t a;
        b_t b;
        c_t c;
    } coef_t;

    localparam sum_t Y_MAX = sum_t'(2**(Y_W-1) - 1);
    localparam sum_t Y_MIN = sum_t'(-(2**(Y_W-1)));
endpackage

// File: rtl/quadra_pipe_if.sv
// Sample stream, result stream and coefficient-write bus of the quadratic evaluator.
interface quadra_pipe_if;
    import quadra_pkg::*;

    logic  in_valid;
    logic  in_ready;
    x_t    in_x;
    logic  in_lin;
    logic  in_rnd;
    logic  out_valid;
    logic  out_ready;
    y_t    out_y;
    logic  out_sat;
    logic  cfg_we;
    x1_t   cfg_addr;
    a_t    cfg_a;
    b_t    cfg_b;
    c_t    cfg_c;

    modport slave (
        input  in_valid, in_x, in_lin, in_rnd, out_ready,
        input  cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c,
        output in_ready, out_valid, out_y, out_sat
    );

    modport master (
        output in_valid, in_x, in_lin, in_rnd, out_ready,
        output cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c,
        input  in_ready, out_valid, out_y, out_sat
    );
endinterface

// File: rtl/quadra_pipe_coef_rf.sv
// Per-segment coefficient table: one write port, one registered read port, cleared on reset.
module quadra_coef_rf
    import quadra_pkg::*;
(
    input  logic  clk,
    input  logic  rst_b,
    input  logic  i_we,
    input  x1_t   i_waddr,
    input  coef_t i_wdata,
    input  logic  i_re,
    input  x1_t   i_raddr,
    output coef_t o_rdata
);
    coef_t r_mem [DEPTH];
    coef_t r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register is the S1 coefficient capture; it only moves on an accepted sample.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/quadra_pipe.sv
// Three-stage piecewise-quadratic evaluator y = a/2 + b*xs + c*sqs with round and saturate.
module quadra_pipe
    import quadra_pkg::*;
(
    input  logic         clk,
    input  logic         rst_b,
    quadra_pipe_if.slave bus
);
    logic  r_s1Valid, r_s2Valid, r_s3Valid;
    logic  w_ld1, w_ld2, w_ld3, w_accept;
    x2_t   r_s1X2;
    logic  r_s1Lin, r_s1Rnd;
    coef_t w_s1Coef;
    coef_t w_cfgCoef;
    xs_t   w_s1Xs;
    logic  [2*X2_W-1:0] w_s1SqFull;
    sq_t   w_s1Sq;
    t1_t   w_s1T1;
    a_t    r_s2A;
    c_t    r_s2C;
    sq_t   r_s2Sq;
    t1_t   r_s2T1;
    logic  r_s2Lin, r_s2Rnd;
    t2_t   w_t2;
    sum_t  w_sum, w_shift, w_rndInc, w_q;
    y_t    w_y;
    logic  w_sat;
    y_t    r_y;
    logic  r_sat;

    // A stage may load when it is empty or its content moves on this edge.
    assign w_ld3        = !r_s3Valid | bus.out_ready;
    assign w_ld2        = !r_s2Valid | w_ld3;
    assign w_ld1        = !r_s1Valid | w_ld2;
    assign bus.in_ready = w_ld1 & !bus.cfg_we;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_cfgCoef    = '{a: bus.cfg_a, b: bus.cfg_b, c: bus.cfg_c};

    quadra_coef_rf u_coefRf (
        .clk     (clk),
        .rst_b   (rst_b),
        .i_we    (bus.cfg_we),
        .i_waddr (bus.cfg_addr),
        .i_wdata (w_cfgCoef),
        .i_re    (w_accept),
        .i_raddr (bus.in_x[X_W-1 -: SEG_W]),
        .o_rdata (w_s1Coef)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_s1Valid <= 1'b0;
            r_s1X2    <= '0;
            r_s1Lin   <= 1'b0;
            r_s1Rnd   <= 1'b0;
        end else if (w_ld1) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1X2  <= bus.in_x[X2_W-1:0];
                r_s1Lin <= bus.in_lin;
                r_s1Rnd <= bus.in_rnd;
            end
        end
    end

    assign w_s1Xs     = r_s1X2[X2_W-1:X2_SHIFT];
    assign w_s1SqFull = {{X2_W{1'b0}}, r_s1X2} * {{X2_W{1'b0}}, r_s1X2};
    assign w_s1Sq     = sq_t'(w_s1SqFull >> (2*X2_SHIFT));
    assign w_s1T1     = (t1_t'(w_s1Coef.b) * t1_t'($signed({1'b0, w_s1Xs}))) >>> T1_SH;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_s2Valid <= 1'b0;
            r_s2A     <= '0;
            r_s2C     <= '0;
            r_s2Sq    <= '0;
            r_s2T1    <= '0;
            r_s2Lin   <= 1'b0;
            r_s2Rnd   <= 1'b0;
        end else if (w_ld2) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2A   <= w_s1Coef.a;
                r_s2C   <= w_s1Coef.c;
                r_s2Sq  <= w_s1Sq;
                r_s2T1  <= w_s1T1;
                r_s2Lin <= r_s1Lin;
                r_s2Rnd <= r_s1Rnd;
            end
        end
    end

    // The sum carries two guard bits over the widest term, so only the final clamp can saturate.
    always_comb begin
        w_t2 = '0;
        if (!r_s2Lin) begin
            w_t2 = (t2_t'(r_s2C) * t2_t'($signed({1'b0, r_s2Sq}))) >>> T2_SH;
        end
        w_sum    = sum_t'(r_s2A >>> 1) + sum_t'(r_s2T1) + sum_t'(w_t2);
        w_shift  = w_sum >>> R_F;
        w_rndInc = sum_t'({1'b0, r_s2Rnd & w_sum[R_F-1]});
        w_q      = w_shift + w_rndInc;
        w_sat    = 1'b0;
        w_y      = w_q[Y_W-1:0];
        if (w_q > Y_MAX) begin
            w_sat = 1'b1;
            w_y   = y_t'(Y_MAX);
        end else if (w_q < Y_MIN) begin
            w_sat = 1'b1;
            w_y   = y_t'(Y_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_s3Valid <= 1'b0;
            r_y       <= '0;
            r_sat     <= 1'b0;
        end else if (w_ld3) begin
            r_s3Valid <= r_s2Valid;
            if (r_s2Valid) begin
                r_y   <= w_y;
                r_sat <= w_sat;
            end
        end
    end

    assign bus.out_valid = r_s3Valid;
    assign bus.out_y     = r_y;
    assign bus.out_sat   = r_sat;
endmodule
